// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stacking-game state producer: FSM encoding, colour-slot
// width and the palette helper that maps a level index to its colour code.
package stack_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MOVE = 3'd1,
    ST_FALL = 3'd2,
    ST_LAND = 3'd3,
    ST_OVER = 3'd4
  } state_e;

  localparam int SLOT_W = 3;

  // Seven-entry palette; code 0 is reserved for an empty level.
  function automatic logic [SLOT_W-1:0] slot_color(input logic [3:0] lvl);
    return SLOT_W'((lvl % 4'd7) + 4'd1);
  endfunction

endpackage

// File: rtl/stack_ctrl_btn_edge.sv
// Button conditioner: two-flop synchroniser followed by a rising-edge detector that
// emits a single-cycle pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [2:0] sh_q, sh_d;

  always_comb sh_d = {sh_q[1:0], din};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sh_q <= '0;
    else      sh_q <= sh_d;
  end

  assign pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/stack_ctrl.sv
// Game-state producer for the stacking game: owns the moving block and the landed stack,
// and exposes block geometry, stack height, packed colours and a per-level read port.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int FLOOR_Y    = 460,
  parameter int BLOCK_H    = 20,
  parameter int INIT_W     = 160,
  parameter int STEP       = 8,
  parameter int MAX_LEVELS = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fall_tick,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       left,
  input  logic                       right,
  output logic [9:0]                 pos_x,
  output logic [9:0]                 pos_y,
  output logic [9:0]                 width,
  output logic [3:0]                 height,
  output logic [SLOT_W*MAX_LEVELS-1:0] colors,
  input  logic [3:0]                 rd_level,
  output logic [9:0]                 rd_x,
  output logic [9:0]                 rd_w,
  output logic                       game_over,
  output logic                       win
);

  localparam logic [9:0] X0   = 10'((SCREEN_W - INIT_W) / 2);
  localparam logic [9:0] W0   = 10'(INIT_W);
  localparam logic [3:0] HMAX = 4'(MAX_LEVELS);

  logic start_p, left_p, right_p, paused;
  logic [1:0] pause_q, pause_d;

  btn_edge u_start (.clk(clk), .rst(rst), .din(start), .pulse(start_p));
  btn_edge u_left  (.clk(clk), .rst(rst), .din(left),  .pulse(left_p));
  btn_edge u_right (.clk(clk), .rst(rst), .din(right), .pulse(right_p));

  state_e                       state_q, state_d;
  logic [9:0]                   pos_x_q, pos_x_d, pos_y_q, pos_y_d, width_q, width_d;
  logic [3:0]                   height_q, height_d;
  logic [SLOT_W*MAX_LEVELS-1:0] colors_q, colors_d;
  logic [9:0]                   lvl_x_q [MAX_LEVELS];
  logic [9:0]                   lvl_x_d [MAX_LEVELS];
  logic [9:0]                   lvl_w_q [MAX_LEVELS];
  logic [9:0]                   lvl_w_d [MAX_LEVELS];
  logic                         miss_q, miss_d, game_over_q, game_over_d, win_q, win_d;

  logic [3:0]  prv_idx;
  logic [10:0] cur_l, cur_r, prv_l, prv_r, ov_l, ov_r, target_y, nx_r, lim_r;

  always_comb pause_d = {pause_q[0], pause};
  assign paused = pause_q[1];

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    width_d     = width_q;
    height_d    = height_q;
    colors_d    = colors_q;
    lvl_x_d     = lvl_x_q;
    lvl_w_d     = lvl_w_q;
    miss_d      = miss_q;
    game_over_d = game_over_q;
    win_d       = win_q;

    // All geometry is widened to 11 bits so x+w never wraps before comparing.
    prv_idx  = (height_q == 4'd0) ? 4'd0 : height_q - 4'd1;
    cur_l    = {1'b0, pos_x_q};
    cur_r    = {1'b0, pos_x_q} + {1'b0, width_q};
    prv_l    = {1'b0, lvl_x_q[prv_idx]};
    prv_r    = prv_l + {1'b0, lvl_w_q[prv_idx]};
    ov_l     = (height_q == 4'd0 || cur_l > prv_l) ? cur_l : prv_l;
    ov_r     = (height_q == 4'd0 || cur_r < prv_r) ? cur_r : prv_r;
    target_y = 11'(FLOOR_Y) - 11'(BLOCK_H) * ({7'd0, height_q} + 11'd1);
    nx_r     = {1'b0, pos_x_q} + 11'(STEP);
    lim_r    = 11'(SCREEN_W) - {1'b0, width_q};

    case (state_q)
      ST_IDLE: if (start_p) state_d = ST_MOVE;
      ST_MOVE: if (!paused) begin
        if (left_p && !right_p)
          pos_x_d = (pos_x_q < 10'(STEP)) ? 10'd0 : pos_x_q - 10'(STEP);
        else if (right_p && !left_p)
          pos_x_d = (nx_r > lim_r) ? 10'(lim_r) : 10'(nx_r);
        if (start_p) state_d = ST_FALL;
      end
      ST_FALL: if (!paused && fall_tick) begin
        if ({1'b0, pos_y_q} == target_y) begin
          // The stack is committed on the terminal tick; LAND then only decides what follows.
          state_d = ST_LAND;
          miss_d  = (height_q != 4'd0) && (ov_r <= ov_l);
          if (height_q == 4'd0 || ov_r > ov_l) begin
            lvl_x_d[height_q] = 10'(ov_l);
            lvl_w_d[height_q] = 10'(ov_r - ov_l);
            colors_d[SLOT_W*height_q +: SLOT_W] = slot_color(height_q);
            height_d = height_q + 4'd1;
          end
        end else begin
          pos_y_d = pos_y_q + 10'(BLOCK_H);
        end
      end
      ST_LAND: begin
        if (miss_q) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
          win_d       = 1'b0;
        end else if (height_q == HMAX) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
          win_d       = 1'b1;
        end else begin
          state_d = ST_MOVE;
          pos_x_d = lvl_x_q[prv_idx];
          width_d = lvl_w_q[prv_idx];
          pos_y_d = 10'd0;
        end
      end
      ST_OVER: if (start_p) begin
        state_d     = ST_MOVE;
        pos_x_d     = X0;
        pos_y_d     = 10'd0;
        width_d     = W0;
        height_d    = 4'd0;
        colors_d    = '0;
        lvl_x_d     = '{default: '0};
        lvl_w_d     = '{default: '0};
        miss_d      = 1'b0;
        game_over_d = 1'b0;
        win_d       = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pause_q     <= '0;
      pos_x_q     <= X0;
      pos_y_q     <= '0;
      width_q     <= W0;
      height_q    <= '0;
      colors_q    <= '0;
      lvl_x_q     <= '{default: '0};
      lvl_w_q     <= '{default: '0};
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      width_q     <= width_d;
      height_q    <= height_d;
      colors_q    <= colors_d;
      lvl_x_q     <= lvl_x_d;
      lvl_w_q     <= lvl_w_d;
      miss_q      <= miss_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign width     = width_q;
  assign height    = height_q;
  assign colors    = colors_q;
  assign game_over = game_over_q;
  assign win       = win_q;
  assign rd_x      = (rd_level < height_q) ? lvl_x_q[rd_level] : 10'd0;
  assign rd_w      = (rd_level < height_q) ? lvl_w_q[rd_level] : 10'd0;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: expectations are queued as stimulus is applied and
// compared against the DUT outputs once the corresponding result is due.
module tb_stack_ctrl;

  logic        clk = 1'b0, rst = 1'b0;
  logic        fall_tick = 1'b0, start = 1'b0, pause = 1'b0, left = 1'b0, right = 1'b0;
  logic [3:0]  rd_level = 4'd0;
  logic [9:0]  pos_x, pos_y, width, rd_x, rd_w;
  logic [3:0]  height;
  logic [32:0] colors;
  logic        game_over, win;

  stack_ctrl dut (
    .clk(clk), .rst(rst), .fall_tick(fall_tick), .start(start), .pause(pause),
    .left(left), .right(right), .pos_x(pos_x), .pos_y(pos_y), .width(width),
    .height(height), .colors(colors), .rd_level(rd_level), .rd_x(rd_x), .rd_w(rd_w),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  localparam int S_X = 0, S_Y = 1, S_W = 2, S_H = 3, S_C = 4, S_RX = 5, S_RW = 6, S_GO = 7, S_WIN = 8;

  typedef struct {
    string  tag;
    int     sel;
    int     lvl;
    longint val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Bench-side game model
  int m_x = 240, m_w = 160, m_h = 0;
  int lx[11], lw[11];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic expect_val(input string tag, input int sel, input int lvl, input longint val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.lvl = lvl; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t   e;
    longint obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_X:   obs = pos_x;
        S_Y:   obs = pos_y;
        S_W:   obs = width;
        S_H:   obs = height;
        S_C:   obs = colors;
        S_RX:  begin rd_level = 4'(e.lvl); #1; obs = rd_x; end
        S_RW:  begin rd_level = 4'(e.lvl); #1; obs = rd_w; end
        S_GO:  obs = game_over;
        default: obs = win;
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  function automatic longint exp_colors(input int h);
    longint c = 0;
    for (int k = 0; k < h; k++) c |= longint'((k % 7) + 1) << (3 * k);
    return c;
  endfunction

  task automatic expect_reset_geom(input string tag);
    expect_val({tag, "_x"}, S_X, 0, 240);
    expect_val({tag, "_y"}, S_Y, 0, 0);
    expect_val({tag, "_w"}, S_W, 0, 160);
    expect_val({tag, "_h"}, S_H, 0, 0);
    expect_val({tag, "_col"}, S_C, 0, 0);
    expect_val({tag, "_go"}, S_GO, 0, 0);
    expect_val({tag, "_win"}, S_WIN, 0, 0);
    expect_val({tag, "_rw0"}, S_RW, 0, 0);
  endtask

  // b: 0 start, 1 left, 2 right, 3 left+right
  task automatic press(input int b);
    @(negedge clk);
    case (b)
      0: start = 1'b1;
      1: left  = 1'b1;
      2: right = 1'b1;
      default: begin left = 1'b1; right = 1'b1; end
    endcase
    repeat (2) @(negedge clk);
    start = 1'b0; left = 1'b0; right = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic move(input int n, input int dir);
    for (int i = 0; i < n; i++) begin
      press(dir);
      if (dir == 1) m_x = (m_x < 8) ? 0 : m_x - 8;
      else          m_x = (m_x + 8 > 640 - m_w) ? 640 - m_w : m_x + 8;
    end
  endtask

  task automatic tick();
    @(negedge clk) fall_tick = 1'b1;
    @(negedge clk) fall_tick = 1'b0;
  endtask

  task automatic drop(input bit do_pause);
    int target, l, r;
    bit hit, over;
    target = 460 - (m_h + 1) * 20;
    press(0);
    if (do_pause) begin
      pause = 1'b1;
      repeat (3) @(negedge clk);
      repeat (5) tick();
      expect_val("pause_y", S_Y, 0, 0);
      drain();
      pause = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (target / 20) tick();
    expect_val("fall_y", S_Y, 0, target);
    drain();
    if (m_h == 0) begin
      l = m_x; r = m_x + m_w;
    end else begin
      l = (m_x > lx[m_h-1]) ? m_x : lx[m_h-1];
      r = (m_x + m_w < lx[m_h-1] + lw[m_h-1]) ? m_x + m_w : lx[m_h-1] + lw[m_h-1];
    end
    hit = (m_h == 0) || (r > l);
    @(negedge clk) fall_tick = 1'b1;
    @(negedge clk) fall_tick = 1'b0;
    if (hit) begin
      lx[m_h] = l; lw[m_h] = r - l; m_h++; m_x = l; m_w = r - l;
    end
    expect_val("land_h", S_H, 0, m_h);
    expect_val("land_col", S_C, 0, exp_colors(m_h));
    drain();
    repeat (3) @(negedge clk);
    over = !hit || (m_h == 11);
    expect_val("land_go", S_GO, 0, over);
    expect_val("land_win", S_WIN, 0, hit && m_h == 11);
    if (m_h > 0) begin
      expect_val("land_rx", S_RX, m_h - 1, lx[m_h-1]);
      expect_val("land_rw", S_RW, m_h - 1, lw[m_h-1]);
    end
    if (!over) begin
      expect_val("spawn_x", S_X, 0, m_x);
      expect_val("spawn_w", S_W, 0, m_w);
      expect_val("spawn_y", S_Y, 0, 0);
    end
    drain();
  endtask

  task automatic model_restart();
    m_x = 240; m_w = 160; m_h = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    expect_reset_geom("rst_in");
    drain();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    press(1);
    expect_reset_geom("idle");
    drain();

    press(0);
    // Edge-to-position latency: no change after two edges, updated after the third.
    @(negedge clk) right = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expect_val("lat_pre", S_X, 0, 240);
    drain();
    @(negedge clk);
    expect_val("lat_post", S_X, 0, 248);
    drain();
    right = 1'b0;
    repeat (3) @(negedge clk);
    m_x = 248;
    move(39, 2);
    expect_val("clamp_r", S_X, 0, 480);
    drain();
    press(3);
    expect_val("both", S_X, 0, 480);
    drain();
    move(30, 1);
    expect_val("back_240", S_X, 0, 240);
    drain();

    drop(1'b0);
    move(5, 2);
    expect_val("move_280", S_X, 0, 280);
    drain();
    drop(1'b0);
    expect_val("col_lvl1", S_C, 0, 33'h11);
    drain();
    drop(1'b1);
    move(35, 1);
    expect_val("clamp_l", S_X, 0, 0);
    drain();
    drop(1'b0);
    expect_val("miss_h", S_H, 0, 3);
    expect_val("miss_go", S_GO, 0, 1);
    drain();

    press(0);
    model_restart();
    expect_reset_geom("restart");
    drain();
    for (int i = 0; i < 11; i++) drop(1'b0);
    expect_val("full_h", S_H, 0, 11);
    expect_val("full_win", S_WIN, 0, 1);
    expect_val("rd_oob", S_RW, 11, 0);
    drain();

    press(0);
    model_restart();
    press(0);
    repeat (3) tick();
    expect_val("midfall_y", S_Y, 0, 60);
    drain();
    #3 rst = 1'b0;
    #1;
    expect_reset_geom("async_rst");
    drain();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    press(2);
    expect_val("post_rst_idle", S_X, 0, 240);
    drain();
    press(0);
    press(2);
    expect_val("post_rst_move", S_X, 0, 248);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
